booth_mult_seq: RTL and testbench
=================================

Name: booth_mult_seq

Overview:
- Sequential radix-2 Booth signed multiplier controller for the Position fixed-point path.
- Sequences a sign-preserving arithmetic right-shift datapath over the register {A, Q, q_1}, one step per clock.
- Each step inspects the Q LSB and q_1, conditionally adds or subtracts the multiplicand, then shifts.
- Used for heading/odometry scaling where a combinational multiplier is too costly.

Parameters:
- WIDTH, 16, operand width in bits. Product is 2*WIDTH bits. Legal range is 4..32.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request pulse. Sampled only in IDLE.
- multiplicand  input  WIDTH  signed two's-complement operand M. Captured on the accepted start.
- multiplier  input  WIDTH  signed two's-complement operand. Captured into Q on the accepted start.
- busy  output  1  high in RUN and DONE.
- done  output  1  one-cycle pulse; product is valid from this cycle.
- product  output  2*WIDTH  signed result. Holds until the next done or rst.

Behaviour:
- Reset values (rst sampled high at a clk edge):
  - state=IDLE; busy=0; done=0; product=0.
  - A, Q, q_1, M and cnt all cleared.
- Internal registers:
  - A is WIDTH+1 bits, so that M = -2^(WIDTH-1) can be subtracted without overflow.
  - Q is WIDTH bits; q_1 is 1 bit; M is WIDTH bits; cnt is $clog2(WIDTH+1) bits.
- States are IDLE, RUN and DONE.
- IDLE:
  - busy=0, done=0.
  - If start=1: A<=0, Q<=multiplier, q_1<=0, M<=multiplicand, cnt<=WIDTH, go to RUN.
- RUN, one Booth step per cycle:
  - {Q[0],q_1}=01: A' = A + sext(M).
  - {Q[0],q_1}=10: A' = A - sext(M).
  - 00 or 11: A' = A.
  - Then arithmetic shift right by 1 of {A',Q,q_1}: the MSB of A' is replicated and the old Q[0] goes to q_1.
  - cnt decrements by 1. When cnt==1 in this cycle, go to DONE.
- DONE:
  - product <= {A[WIDTH-1:0], Q}; done=1 for exactly this cycle; busy=1.
  - Next state is IDLE unconditionally.
- Latency:
  - start sampled at edge 0 gives WIDTH RUN cycles.
  - done is high in the cycle after edge WIDTH+1 (17 cycles for WIDTH=16).
  - Throughput is one result per WIDTH+2 cycles.
- start while busy (RUN or DONE): ignored, with no effect on the in-flight operation or the operands. Operand inputs are don't-care except in the IDLE+start cycle.
- Reset mid-operation: abort at the next edge and return to IDLE. product clears to 0 and done is not asserted.
- Arithmetic: full precision; the result is exact for all operand pairs, including -2^(WIDTH-1) * -2^(WIDTH-1), with no saturation.
- done and busy are registered outputs, with no combinational path from inputs.

Test Plan:
- WIDTH=16, start with M=3, multiplier=5 -> done exactly 17 cycles after the start edge; product=0x0000000F; busy high 17 cycles.
- M=-7 (0xFFF9), multiplier=6 -> product=0xFFFFFFD6 (-42); next, M=0, multiplier=0x1234 -> product=0x00000000.
- M=0x8000, multiplier=0x8000 -> product=0x40000000. Then M=0x7FFF, multiplier=0x8000 -> product=0xC0008000.
- Start pulsed again in the RUN and DONE cycles with different operands -> ignored; the first result is unchanged; the next start in IDLE is accepted with correct latency.
- rst asserted at cycle 8 of RUN -> next cycle busy=0, done=0, product=0; no done pulse follows. A new start then yields a correct result.
- Randomised 1000 operand pairs, including the extremes 0x8000 and 0x7FFF, checked against a signed reference model; done is always a single-cycle pulse and product is stable between done pulses.

Source files
------------

// File: rtl/booth_mult_seq_if.sv
// Request/result bundle for the sequential Booth multiplier.
// The master issues start with operands; the slave returns busy, done and product.
interface booth_mult_seq_if #(
    parameter int WIDTH = 16
);
    logic                 start;
    logic [WIDTH-1:0]     multiplicand;
    logic [WIDTH-1:0]     multiplier;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   product;

    modport master (
        output start, multiplicand, multiplier,
        input  busy, done, product
    );

    modport slave (
        input  start, multiplicand, multiplier,
        output busy, done, product
    );
endinterface

// File: rtl/booth_mult_seq.sv
// Sequential radix-2 Booth signed multiplier: one add/subtract-and-shift step per clock
// over {a, q, q_1}. A result appears WIDTH+1 edges after an accepted start.
module booth_mult_seq #(
    parameter int WIDTH = 16
) (
    input  logic              clk,
    input  logic              rst,
    booth_mult_seq_if.slave   bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t              state, state_next;
    logic [WIDTH:0]      a, a_sum, m_ext;
    logic [WIDTH-1:0]    q, m;
    logic                q_1;
    logic [CW-1:0]       cnt;
    logic                busy_r, done_r;
    logic [2*WIDTH-1:0]  product_r;

    // a carries one guard bit so subtracting M = -2^(WIDTH-1) cannot overflow.
    assign m_ext = {m[WIDTH-1], m};

    // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.start) state_next = RUN;
            RUN:     if (cnt == CW'(1)) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        a_sum = a;
        case ({q[0], q_1})
            2'b01:   a_sum = a + m_ext;
            2'b10:   a_sum = a - m_ext;
            default: a_sum = a;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            product_r <= '0;
        end else begin
            state  <= state_next;
            busy_r <= (state_next != IDLE);
            done_r <= (state == DONE);
            if (state == DONE)
                product_r <= {a[WIDTH-1:0], q};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a   <= '0;
            q   <= '0;
            q_1 <= 1'b0;
            m   <= '0;
            cnt <= '0;
        end else begin
            case (state)
                IDLE: if (bus.start) begin
                    a   <= '0;
                    q   <= bus.multiplier;
                    q_1 <= 1'b0;
                    m   <= bus.multiplicand;
                    cnt <= CW'(WIDTH);
                end
                RUN: begin
                    // Arithmetic shift right of {a_sum, q, q_1}.
                    a   <= {a_sum[WIDTH], a_sum[WIDTH:1]};
                    q   <= {a_sum[0], q[WIDTH-1:1]};
                    q_1 <= q[0];
                    cnt <= cnt - CW'(1);
                end
                default: ;
            endcase
        end
    end

    assign bus.busy    = busy_r;
    assign bus.done    = done_r;
    assign bus.product = product_r;
endmodule

// File: tb/tb_booth_mult_seq.sv
// Directed and randomised checks of booth_mult_seq at WIDTH=16: latency, busy span,
// done pulse width, product hold, ignored restarts and mid-operation reset.
module tb_booth_mult_seq;
    localparam int W = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    booth_mult_seq_if #(.WIDTH(W)) bus ();
    booth_mult_seq #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Issue one operation and check latency, busy span, product and done pulse width.
    // With poke set, start is re-asserted with other operands in RUN and in DONE.
    task automatic run_op(input logic [W-1:0] m, input logic [W-1:0] mq,
                          input logic [2*W-1:0] exp, input bit poke);
        int n = 0;
        int busy_cnt = 0;
        bit got = 0;
        bit stable = 1;
        logic [2*W-1:0] prev;
        @(negedge clk);
        prev = bus.product;
        bus.start        = 1'b1;
        bus.multiplicand = m;
        bus.multiplier   = mq;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.multiplicand = ~m;
        bus.multiplier   = ~mq;
        if (bus.busy) busy_cnt++;
        while (!got && n < 40) begin
            @(posedge clk);
            n++;
            #1;
            if (poke && (n == 5 || n == 16)) bus.start = 1'b1;
            if (poke && (n == 6 || n == 17)) bus.start = 1'b0;
            if (bus.done) got = 1;
            else begin
                if (bus.busy) busy_cnt++;
                if (bus.product !== prev) stable = 0;
            end
        end
        bus.start = 1'b0;
        chk("done_seen", 64'(got), 64'd1);
        chk("latency", 64'(n), 64'(W + 1));
        chk("busy_cycles", 64'(busy_cnt), 64'(W + 1));
        chk("product_hold", 64'(stable), 64'd1);
        chk("product", 64'(bus.product), 64'(exp));
        @(posedge clk);
        #1;
        chk("done_pulse", 64'(bus.done), 64'd0);
        chk("product_keep", 64'(bus.product), 64'(exp));
    endtask

    initial begin
        logic [W-1:0] rm, rq;
        logic signed [2*W-1:0] ref_p;
        bit seen_done;
        logic [W-1:0] extremes [4];

        bus.start = 1'b0;
        bus.multiplicand = '0;
        bus.multiplier   = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
        chk("rst_product", 64'(bus.product), 64'd0);

        run_op(16'd3,    16'd5,    32'h0000_000F, 0);
        run_op(16'hFFF9, 16'd6,    32'hFFFF_FFD6, 0);
        run_op(16'h0000, 16'h1234, 32'h0000_0000, 0);
        run_op(16'h8000, 16'h8000, 32'h4000_0000, 0);
        run_op(16'h7FFF, 16'h8000, 32'hC000_8000, 0);

        // Restarts during RUN and DONE must not disturb the in-flight result.
        run_op(16'd100,  16'hFFFE, 32'hFFFF_FF38, 1);
        run_op(16'h7FFF, 16'h7FFF, 32'h3FFF_0001, 0);

        // Reset in the middle of RUN.
        @(negedge clk);
        bus.start = 1'b1;
        bus.multiplicand = 16'd9;
        bus.multiplier   = 16'd9;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("abort_busy", 64'(bus.busy), 64'd0);
        chk("abort_done", 64'(bus.done), 64'd0);
        chk("abort_product", 64'(bus.product), 64'd0);
        seen_done = 0;
        repeat (25) begin
            @(posedge clk);
            #1;
            if (bus.done) seen_done = 1;
        end
        chk("abort_no_done", 64'(seen_done), 64'd0);
        run_op(16'hFFFF, 16'hFFFF, 32'h0000_0001, 0);

        extremes[0] = 16'h8000;
        extremes[1] = 16'h7FFF;
        extremes[2] = 16'hFFFF;
        extremes[3] = 16'h0000;
        for (int i = 0; i < 1000; i++) begin
            rm = W'($urandom);
            rq = W'($urandom);
            if ($urandom_range(0, 7) == 0) rm = extremes[$urandom_range(0, 3)];
            if ($urandom_range(0, 7) == 0) rq = extremes[$urandom_range(0, 3)];
            ref_p = $signed(rm) * $signed(rq);
            run_op(rm, rq, ref_p, (i % 10) == 3);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
